// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-outstanding data-memory port with byte strobes,
// load extraction/extension and pipeline stall while an access is in flight.
//
// state | meaning
// IDLE  | no access in flight; legal mop launches a request, bad mop raises fault_o
// REQ   | dmem_req_o held with stable fields until dmem_gnt_i
// WAIT  | granted, waiting for dmem_rvalid_i
// DONE  | done_o pulse, pipeline released for one cycle
module mem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid_i,
  input  logic              op_load_i,
  input  logic              op_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       store_data_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  output logic [3:0]        dmem_wstrb_o,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic [31:0]       load_data_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              fault_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        load_q;

  logic        is_mop;
  logic        f3_legal;
  logic        misaligned;
  logic        mop_ok;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic [31:0] resp_data;

  function automatic logic [31:0] extract(input logic [31:0] rdata,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  off);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b100:  res = {24'h0, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b101:  res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  assign is_mop = op_valid_i & (op_load_i | op_store_i);

  // load takes priority if both op_load_i and op_store_i are set
  always_comb begin
    f3_legal = 1'b0;
    if (op_load_i) begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end
  end

  assign misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                      ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
  assign mop_ok     = is_mop & f3_legal & ~misaligned;

  assign fault_o = (state == IDLE) & is_mop & ~(f3_legal & ~misaligned);
  assign stall_o = ((state == IDLE) & mop_ok) | (state == REQ) | (state == WAIT);

  always_comb begin
    wstrb_n = 4'b1111;
    wdata_n = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_n = 4'b0001 << addr_i[1:0];
        wdata_n = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        wstrb_n = 4'b0011 << addr_i[1:0];
        wdata_n = {2{store_data_i[15:0]}};
      end
      default: begin
        wstrb_n = 4'b1111;
        wdata_n = store_data_i;
      end
    endcase
    if (op_load_i) wstrb_n = 4'b0000;
  end

  assign resp_data = load_q ? extract(dmem_rdata_i, f3_q, off_q) : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= 32'h0;
      dmem_wstrb_o <= 4'h0;
      load_data_o  <= 32'h0;
      done_o       <= 1'b0;
      f3_q         <= 3'h0;
      off_q        <= 2'h0;
      load_q       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mop_ok) begin
            state        <= REQ;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= ~op_load_i;
            dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            dmem_wdata_o <= wdata_n;
            dmem_wstrb_o <= wstrb_n;
            f3_q         <= funct3_i;
            off_q        <= addr_i[1:0];
            load_q       <= op_load_i;
          end
        end
        REQ: begin
          // rvalid before the grant is a protocol error and is dropped
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_rvalid_i) begin
              state       <= DONE;
              done_o      <= 1'b1;
              load_data_o <= resp_data;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            state       <= DONE;
            done_o      <= 1'b1;
            load_data_o <= resp_data;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-level reference memory, randomized memory responder,
// request/response scoreboard and directed corner cases.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid_i, op_load_i, op_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic        dmem_req_o, dmem_gnt_i, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] load_data_o;
  logic        done_o, stall_o, fault_o;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid_i(op_valid_i), .op_load_i(op_load_i), .op_store_i(op_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .load_data_o(load_data_o), .done_o(done_o), .stall_o(stall_o), .fault_o(fault_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] ldata;
  } exp_t;

  exp_t exp_q[$];

  // reference memory (bytes) and the responder's physical memory (words)
  logic [7:0]  ref_mem  [0:1023];
  logic [31:0] phys_mem [0:255];

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[a + i] = w[8*i +: 8];
    phys_mem[a[9:2]] = w;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int          size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    v = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a + i]) << (8*i));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
    return v;
  endfunction

  // responder: random (or forced) grant delay, same-cycle rvalid, response latency
  logic        force_en = 1'b0;
  int          f_gw = 0, f_lat = 0;
  logic        f_same = 1'b0;
  int          exp_stall = 0;
  logic        have_plan, pending, plan_same;
  int          plan_gw, plan_lat;
  logic [31:0] resp_word;

  initial begin
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    have_plan = 1'b0; pending = 1'b0; plan_same = 1'b0;
    plan_gw = 0; plan_lat = 0; resp_word = 32'h0;
    forever begin
      @(negedge clk);
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
      if (!rst_n) have_plan = 1'b0;
      if (pending) begin
        if (plan_lat == 0) begin
          dmem_rvalid_i = 1'b1; dmem_rdata_i = resp_word; pending = 1'b0;
        end else plan_lat--;
      end else if (rst_n && dmem_req_o) begin
        if (!have_plan) begin
          if (force_en) begin
            plan_gw = f_gw; plan_same = f_same; plan_lat = f_lat;
          end else begin
            plan_gw = $urandom_range(0, 3); plan_same = 1'($urandom_range(0, 1));
            plan_lat = $urandom_range(0, 3);
          end
          have_plan = 1'b1;
          exp_stall = 2 + plan_gw + (plan_same ? 0 : plan_lat + 1);
        end
        if (plan_gw == 0) begin
          dmem_gnt_i = 1'b1; have_plan = 1'b0;
          if (dmem_we_o) begin
            for (int b = 0; b < 4; b++)
              if (dmem_wstrb_o[b]) phys_mem[dmem_addr_o[9:2]][8*b +: 8] = dmem_wdata_o[8*b +: 8];
            resp_word = $urandom;
          end else resp_word = phys_mem[dmem_addr_o[9:2]];
          if (plan_same) begin
            dmem_rvalid_i = 1'b1; dmem_rdata_i = resp_word;
          end else pending = 1'b1;
        end else plan_gw--;
      end
    end
  end

  // monitor: request fields against the head of the queue, completions pop it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (rst_n) begin
        if (dmem_req_o) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL req_unexpected actual=dmem_req_o=1 required=no request");
          end else begin
            e = exp_q[0];
            chk("req_we", 32'(dmem_we_o), 32'(e.we));
            chk("req_addr", dmem_addr_o, e.addr);
            if (e.we) begin
              chk("req_wstrb", 32'(dmem_wstrb_o), 32'(e.wstrb));
              chk("req_wdata", dmem_wdata_o, e.wdata);
            end else chk("req_load_wstrb", 32'(dmem_wstrb_o), 32'h0);
          end
        end
        if (done_o) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_unexpected actual=done_o=1 required=no completion");
          end else begin
            e = exp_q.pop_front();
            chk("load_data", load_data_o, e.ldata);
          end
        end
      end
    end
  end

  task automatic do_op(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       output int stalls, output logic [31:0] ld_out);
    int   size;
    logic legal, good, mop, seen;
    exp_t e;
    mop   = v && (ld || st);
    size  = 1 << f3[1:0];
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    good  = mop && legal && ((a % size) == 0);
    stalls = 0; ld_out = 32'h0;
    @(negedge clk);
    op_valid_i = v; op_load_i = ld; op_store_i = st;
    funct3_i = f3; addr_i = a; store_data_i = sd;
    if (good) begin
      e.we    = !ld;
      e.addr  = a & ~32'h3;
      e.wstrb = 4'(((1 << size) - 1) << (a % 4));
      case (size)
        1:       e.wdata = {4{sd[7:0]}};
        2:       e.wdata = {2{sd[15:0]}};
        default: e.wdata = sd;
      endcase
      e.ldata = ld ? ref_load(a, f3) : 32'h0;
      if (!ld) for (int i = 0; i < size; i++) ref_mem[a + i] = sd[8*i +: 8];
      exp_q.push_back(e);
    end
    #1;
    if (!good) begin
      chk("fault_flag", 32'(fault_o), 32'(mop));
      chk("fault_no_stall", 32'(stall_o), 32'h0);
      @(negedge clk); #1;
      chk("idle_fault_hold", 32'(fault_o), 32'(mop));
      chk("idle_no_req", 32'(dmem_req_o), 32'h0);
      chk("idle_no_stall", 32'(stall_o), 32'h0);
      op_valid_i = 1'b0;
      return;
    end
    chk("issue_stall", 32'(stall_o), 32'h1);
    chk("issue_fault", 32'(fault_o), 32'h0);
    stalls = 1; seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk); #1;
      if (done_o) seen = 1'b1;
      else if (stall_o) stalls++;
    end
    op_valid_i = 1'b0;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no done_o required=done_o within 40 cycles");
    end else begin
      ld_out = load_data_o;
      chk("done_stall_low", 32'(stall_o), 32'h0);
      chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    end
  endtask

  initial begin
    int          stalls, r, cnt;
    logic [31:0] ldv, a, sd;
    logic [2:0]  f3;
    logic        v, ld, st;

    rst_n = 1'b0; op_valid_i = 1'b0; op_load_i = 1'b0; op_store_i = 1'b0;
    funct3_i = 3'h0; addr_i = 32'h0; store_data_i = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 8'($urandom);
      phys_mem[i/4][8*(i%4) +: 8] = ref_mem[i];
    end
    set_word(32'h100, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(dmem_req_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_ldata", load_data_o, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    rst_n = 1'b1;

    force_en = 1'b1; f_gw = 0; f_same = 1'b1; f_lat = 0;
    do_op(1, 1, 0, 3'b010, 32'h100, 32'h0, stalls, ldv);
    chk("lw_min_stalls", 32'(stalls), 32'd2);
    chk("lw_data", ldv, 32'hDEADBEEF);

    set_word(32'h100, 32'h80112233);
    do_op(1, 1, 0, 3'b000, 32'h103, 32'h0, stalls, ldv);
    chk("lb_data", ldv, 32'hFFFFFF80);
    do_op(1, 1, 0, 3'b100, 32'h103, 32'h0, stalls, ldv);
    chk("lbu_data", ldv, 32'h00000080);

    do_op(1, 0, 1, 3'b001, 32'h202, 32'h1234ABCD, stalls, ldv);
    chk("sh_ldata_zero", ldv, 32'h0);

    do_op(1, 1, 0, 3'b001, 32'h101, 32'h0, stalls, ldv);
    do_op(1, 0, 1, 3'b010, 32'h102, 32'h55AA55AA, stalls, ldv);

    f_gw = 2; f_same = 1'b0; f_lat = 1;
    do_op(1, 1, 0, 3'b010, 32'h300, 32'h0, stalls, ldv);
    chk("delayed_stalls", 32'(stalls), 32'd6);
    cnt = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (done_o) cnt++;
    end
    chk("done_single", 32'(cnt), 32'h0);

    // reset while in WAIT; the late rvalid must be ignored
    f_gw = 0; f_same = 1'b0; f_lat = 6;
    set_word(32'h40, 32'hCAFEF00D);
    @(negedge clk);
    op_valid_i = 1'b1; op_load_i = 1'b1; op_store_i = 1'b0;
    funct3_i = 3'b010; addr_i = 32'h40; store_data_i = 32'h0;
    exp_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, wstrb: 4'h0, ldata: 32'hCAFEF00D});
    @(negedge clk);
    @(negedge clk); #1;
    chk("wait_stall", 32'(stall_o), 32'h1);
    rst_n = 1'b0; op_valid_i = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_req", 32'(dmem_req_o), 32'h0);
    chk("mid_rst_we", 32'(dmem_we_o), 32'h0);
    chk("mid_rst_addr", dmem_addr_o, 32'h0);
    chk("mid_rst_wdata", dmem_wdata_o, 32'h0);
    chk("mid_rst_wstrb", 32'(dmem_wstrb_o), 32'h0);
    chk("mid_rst_ldata", load_data_o, 32'h0);
    chk("mid_rst_done", 32'(done_o), 32'h0);
    chk("mid_rst_stall", 32'(stall_o), 32'h0);
    exp_q.delete();
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (done_o) cnt++;
    end
    chk("late_rvalid_no_done", 32'(cnt), 32'h0);
    force_en = 1'b0;
    do_op(1, 1, 0, 3'b010, 32'h40, 32'h0, stalls, ldv);
    chk("post_rst_lw", ldv, 32'hCAFEF00D);

    for (int k = 0; k < 250; k++) begin
      r  = $urandom_range(0, 9);
      ld = 1'($urandom_range(0, 1)); st = !ld; v = 1'b1; sd = $urandom;
      if (r == 0) begin
        v = 1'($urandom_range(0, 1));
        if (v) begin ld = 1'b0; st = 1'b0; end
        f3 = 3'($urandom_range(0, 7));
        a  = $urandom_range(0, 1023);
      end else if (r == 1) begin
        if ($urandom_range(0, 1) == 1) begin
          if (ld) begin
            case ($urandom_range(0, 2))
              0:       f3 = 3'd3;
              1:       f3 = 3'd6;
              default: f3 = 3'd7;
            endcase
          end else f3 = 3'($urandom_range(3, 7));
          a = $urandom_range(0, 1023);
        end else begin
          f3 = 3'($urandom_range(1, 2));
          if (ld && f3 == 3'd1 && $urandom_range(0, 1) == 1) f3 = 3'd5;
          a = (32'($urandom_range(0, 1023)) & ~32'h3) |
              ((f3[1:0] == 2'b01) ? 32'h1 : 32'($urandom_range(1, 3)));
        end
      end else begin
        if (ld) begin
          case ($urandom_range(0, 4))
            0:       f3 = 3'd0;
            1:       f3 = 3'd1;
            2:       f3 = 3'd2;
            3:       f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
        end else f3 = 3'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 1023)) & ~((32'd1 << f3[1:0]) - 32'd1);
      end
      do_op(v, ld, st, f3, a, sd, stalls, ldv);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
